// File: rtl/inst_fetch_unit.sv
// Program store and instruction supplier for the 8-bit Micro core.
// Loads a program over a valid/ready byte stream, then serves INST for each PC until HALT.
module inst_fetch_unit #(
  parameter int unsigned         INST_W  = 8,
  parameter int unsigned         DEPTH   = 32,
  parameter int unsigned         AW      = 5,
  parameter logic [INST_W-1:0]   NOP_OP  = INST_W'(8'h00),
  parameter logic [INST_W-1:0]   HALT_OP = INST_W'(8'hFF)
) (
  input  logic              clk,
  input  logic              CLB,
  input  logic              start,
  input  logic              ld_valid,
  input  logic [INST_W-1:0] ld_data,
  output logic              ld_ready,
  input  logic [7:0]        PC,
  output logic [INST_W-1:0] INST,
  output logic              inst_valid,
  output logic              run,
  output logic              halted,
  output logic [AW:0]       load_count,
  output logic              err_overflow
);

  localparam int unsigned CMP_W     = ((AW + 1) > 8) ? (AW + 1) : 8;
  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next_state;

  logic [INST_W-1:0]   r_mem [DEPTH];
  logic [INST_W-1:0]   r_inst;
  logic                r_inst_valid;
  logic                r_halted;
  logic [AW:0]         r_load_count;
  logic                r_err_overflow;

  logic                w_ld_ready;
  logic                w_beat;
  logic                w_overflow_attempt;
  logic                w_start_run;
  logic                w_pc_in_range;
  logic [INST_W-1:0]   w_mem_word;
  logic [INST_W-1:0]   w_fetch_word;
  logic                w_fetch_halt;

  // Load handshake and fetch decode
  assign w_ld_ready         = (r_state == S_IDLE) && (r_load_count < DEPTH_CNT);
  assign w_beat             = ld_valid && w_ld_ready;
  assign w_overflow_attempt = (r_state == S_IDLE) && ld_valid && (r_load_count == DEPTH_CNT);
  // A beat landing with start counts toward the program length
  assign w_start_run        = start && ((r_load_count != '0) || w_beat);

  // PC is never wrapped: compare full PC against the zero-extended count
  assign w_pc_in_range = CMP_W'(PC) < CMP_W'(r_load_count);
  assign w_mem_word    = r_mem[PC[AW-1:0]];
  assign w_fetch_word  = w_pc_in_range ? w_mem_word : NOP_OP;
  assign w_fetch_halt  = w_pc_in_range && (w_mem_word == HALT_OP);

  // State register
  always_ff @(posedge clk or posedge CLB) begin
    if (CLB) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start_run) begin
          w_next_state = S_RUN;
        end
      end
      S_RUN: begin
        if (w_fetch_halt) begin
          w_next_state = S_HALT;
        end
      end
      S_HALT: begin
        if (start) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    ld_ready = 1'b0;
    run      = 1'b0;
    case (r_state)
      S_IDLE:  ld_ready = w_ld_ready;
      S_RUN:   run      = 1'b1;
      default: begin
        ld_ready = 1'b0;
        run      = 1'b0;
      end
    endcase
  end

  // Program store; contents survive reset by design
  always_ff @(posedge clk) begin
    if (w_beat) begin
      r_mem[r_load_count[AW-1:0]] <= ld_data;
    end
  end

  // Load counter, fetch register and status flags
  always_ff @(posedge clk or posedge CLB) begin
    if (CLB) begin
      r_inst         <= NOP_OP;
      r_inst_valid   <= 1'b0;
      r_halted       <= 1'b0;
      r_load_count   <= '0;
      r_err_overflow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_inst_valid <= 1'b0;
          if (w_beat) begin
            r_load_count <= r_load_count + (AW + 1)'(1);
          end
          if (w_overflow_attempt) begin
            r_err_overflow <= 1'b1;
          end
        end
        S_RUN: begin
          r_inst       <= w_fetch_word;
          r_inst_valid <= 1'b1;
          if (w_fetch_halt) begin
            r_halted <= 1'b1;
          end
        end
        S_HALT: begin
          r_inst_valid <= 1'b0;
          // Clearing the count makes stale store words unreachable
          if (start) begin
            r_load_count <= '0;
            r_halted     <= 1'b0;
            r_inst       <= NOP_OP;
          end
        end
        default: begin
          r_inst_valid <= 1'b0;
        end
      endcase
    end
  end

  assign INST         = r_inst;
  assign inst_valid   = r_inst_valid;
  assign halted       = r_halted;
  assign load_count   = r_load_count;
  assign err_overflow = r_err_overflow;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: a behavioural program-store model checked every cycle,
// plus directed vectors with literal expectations.
module tb_inst_fetch_unit;

  logic       clk = 1'b0;
  logic       CLB = 1'b1;
  logic       start = 1'b0;
  logic       ld_valid = 1'b0;
  logic [7:0] ld_data = 8'h00;
  logic [7:0] PC = 8'h00;
  logic       ld_ready;
  logic [7:0] INST;
  logic       inst_valid;
  logic       run;
  logic       halted;
  logic [5:0] load_count;
  logic       err_overflow;

  int n_vec = 0;
  int n_bad = 0;

  inst_fetch_unit dut (
    .clk          (clk),
    .CLB          (CLB),
    .start        (start),
    .ld_valid     (ld_valid),
    .ld_data      (ld_data),
    .ld_ready     (ld_ready),
    .PC           (PC),
    .INST         (INST),
    .inst_valid   (inst_valid),
    .run          (run),
    .halted       (halted),
    .load_count   (load_count),
    .err_overflow (err_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0 = loading, 1 = running, 2 = stopped
  int         m_mode;
  int         m_count;
  logic [7:0] m_prog [32];
  logic [7:0] m_inst;
  bit         m_valid;
  bit         m_halted;
  bit         m_err;

  always @(posedge clk or posedge CLB) begin
    if (CLB) begin
      m_mode   <= 0;
      m_count  <= 0;
      m_inst   <= 8'h00;
      m_valid  <= 1'b0;
      m_halted <= 1'b0;
      m_err    <= 1'b0;
    end else begin
      case (m_mode)
        0: begin
          int c;
          c = m_count;
          if (ld_valid && c < 32) begin
            m_prog[c] <= ld_data;
            c = c + 1;
          end
          if (ld_valid && m_count == 32) m_err <= 1'b1;
          m_count <= c;
          m_valid <= 1'b0;
          if (start && c > 0) m_mode <= 1;
        end
        1: begin
          logic [7:0] w;
          w = (PC < m_count) ? m_prog[PC[4:0]] : 8'h00;
          m_inst  <= w;
          m_valid <= 1'b1;
          if (PC < m_count && w == 8'hFF) begin
            m_mode   <= 2;
            m_halted <= 1'b1;
          end
        end
        default: begin
          m_valid <= 1'b0;
          if (start) begin
            m_mode   <= 0;
            m_count  <= 0;
            m_halted <= 1'b0;
            m_inst   <= 8'h00;
          end
        end
      endcase
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (!CLB) begin
      chk("cyc INST", INST, m_inst);
      chk("cyc inst_valid", inst_valid, m_valid);
      chk("cyc run", run, m_mode == 1);
      chk("cyc halted", halted, m_halted);
      chk("cyc load_count", load_count, m_count);
      chk("cyc err_overflow", err_overflow, m_err);
      chk("cyc ld_ready", ld_ready, (m_mode == 0) && (m_count < 32));
    end
  end

  // Apply one cycle of inputs; returns 2 time units after the edge
  task automatic drive(input logic s, input logic v, input logic [7:0] d, input logic [7:0] p);
    start    = s;
    ld_valid = v;
    ld_data  = d;
    PC       = p;
    @(posedge clk);
    #2;
    start    = 1'b0;
    ld_valid = 1'b0;
  endtask

  task automatic do_reset();
    #1 CLB = 1'b1;
    @(posedge clk);
    #2 CLB = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #2 CLB = 1'b0;

    // Reset values
    chk("rst INST", INST, 8'h00);
    chk("rst inst_valid", inst_valid, 1'b0);
    chk("rst run", run, 1'b0);
    chk("rst halted", halted, 1'b0);
    chk("rst load_count", load_count, 6'd0);
    chk("rst err_overflow", err_overflow, 1'b0);
    chk("rst ld_ready", ld_ready, 1'b1);

    // Load 11,22,33,FF and run to HALT
    drive(1'b0, 1'b1, 8'h11, 8'h00);
    drive(1'b0, 1'b1, 8'h22, 8'h00);
    drive(1'b0, 1'b1, 8'h33, 8'h00);
    drive(1'b0, 1'b1, 8'hFF, 8'h00);
    chk("t2 load_count", load_count, 6'd4);
    drive(1'b1, 1'b0, 8'h00, 8'h00);
    chk("t2 run", run, 1'b1);
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    chk("t2 INST pc0", INST, 8'h11);
    chk("t2 valid pc0", inst_valid, 1'b1);
    drive(1'b0, 1'b0, 8'h00, 8'h01);
    chk("t2 INST pc1", INST, 8'h22);
    drive(1'b0, 1'b0, 8'h00, 8'h02);
    chk("t2 INST pc2", INST, 8'h33);
    drive(1'b0, 1'b0, 8'h00, 8'h03);
    chk("t2 INST pc3", INST, 8'hFF);
    chk("t2 valid pc3", inst_valid, 1'b1);
    chk("t2 halted", halted, 1'b1);
    chk("t2 run off", run, 1'b0);
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    chk("t2 valid after halt", inst_valid, 1'b0);
    chk("t2 INST holds", INST, 8'hFF);

    // HALT -> IDLE, reload one word, old data unreachable
    drive(1'b1, 1'b0, 8'h00, 8'h00);
    chk("t6 load_count", load_count, 6'd0);
    chk("t6 halted", halted, 1'b0);
    chk("t6 INST", INST, 8'h00);
    chk("t6 ld_ready", ld_ready, 1'b1);
    drive(1'b0, 1'b1, 8'h44, 8'h00);
    drive(1'b1, 1'b0, 8'h00, 8'h00);
    drive(1'b0, 1'b0, 8'h00, 8'h01);
    chk("t6 INST pc1 stale", INST, 8'h00);
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    chk("t6 INST pc0", INST, 8'h44);
    chk("t6 run", run, 1'b1);

    // Asynchronous reset mid-RUN, checked before the next edge
    #1 CLB = 1'b1;
    #1;
    chk("t1 INST", INST, 8'h00);
    chk("t1 inst_valid", inst_valid, 1'b0);
    chk("t1 run", run, 1'b0);
    chk("t1 load_count", load_count, 6'd0);
    @(posedge clk);
    #2 CLB = 1'b0;

    // start alone ignored; start with a single FF beat runs then halts
    drive(1'b1, 1'b0, 8'h00, 8'h00);
    chk("t5 start ignored run", run, 1'b0);
    chk("t5 start ignored ld_ready", ld_ready, 1'b1);
    drive(1'b1, 1'b1, 8'hFF, 8'h00);
    chk("t5 run", run, 1'b1);
    chk("t5 load_count", load_count, 6'd1);
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    chk("t5 INST", INST, 8'hFF);
    chk("t5 halted", halted, 1'b1);
    chk("t5 run off", run, 1'b0);
    do_reset();

    // Out-of-range PCs return NOP without halting; start/ld_valid ignored in RUN
    drive(1'b0, 1'b1, 8'hA1, 8'h00);
    drive(1'b0, 1'b1, 8'hA2, 8'h00);
    drive(1'b1, 1'b0, 8'h00, 8'h00);
    drive(1'b0, 1'b0, 8'h00, 8'h05);
    chk("t3 INST pc5", INST, 8'h00);
    chk("t3 halted pc5", halted, 1'b0);
    drive(1'b1, 1'b1, 8'h55, 8'd200);
    chk("t3 INST pc200", INST, 8'h00);
    chk("t3 load_count held", load_count, 6'd2);
    chk("t3 run", run, 1'b1);
    drive(1'b0, 1'b0, 8'h00, 8'h01);
    chk("t3 INST pc1", INST, 8'hA2);
    do_reset();

    // 33 back-to-back beats into a 32-word store
    for (int i = 1; i <= 33; i++) begin
      drive(1'b0, 1'b1, 8'(i), 8'h00);
      if (i == 32) begin
        chk("t4 ld_ready full", ld_ready, 1'b0);
        chk("t4 load_count full", load_count, 6'd32);
        chk("t4 err before", err_overflow, 1'b0);
      end
    end
    chk("t4 err after", err_overflow, 1'b1);
    chk("t4 load_count after", load_count, 6'd32);
    drive(1'b1, 1'b0, 8'h00, 8'h00);
    drive(1'b0, 1'b0, 8'h00, 8'd31);
    chk("t4 INST pc31", INST, 8'h20);
    drive(1'b0, 1'b0, 8'h00, 8'd0);
    chk("t4 INST pc0", INST, 8'h01);
    drive(1'b0, 1'b0, 8'h00, 8'd32);
    chk("t4 INST pc32", INST, 8'h00);
    chk("t4 err sticky", err_overflow, 1'b1);
    do_reset();
    chk("t4 err cleared", err_overflow, 1'b0);

    repeat (2) @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Program store and instruction supplier for the 8-bit Micro core.
- It is the instruction-side counterpart of the core: the core drives PC and consumes INST.
- The block loads a program through a valid/ready byte stream, then returns INST for every PC the core presents.
- Execution stops when a HALT opcode is fetched.

Parameters:
INST_W, 8, instruction word width
DEPTH, 32, program store depth in words
AW, 5, store address width (log2 DEPTH)
NOP_OP, 8'h00, word returned for an out-of-range PC
HALT_OP, 8'hFF, opcode that stops execution

Ports:
clk  input  1  system clock, rising edge
CLB  input  1  reset, asynchronous, active-high
start  input  1  single-cycle pulse: begin run (IDLE) or return to IDLE (HALT)
ld_valid  input  1  load beat valid
ld_data  input  INST_W  load beat data
ld_ready  output  1  load beat accepted when ld_valid && ld_ready
PC  input  8  program counter from the core
INST  output  INST_W  registered instruction to the core
inst_valid  output  1  INST is a live fetch
run  output  1  core enable
halted  output  1  HALT_OP fetched
load_count  output  AW+1  number of words loaded
err_overflow  output  1  sticky: load attempted while store full

Behaviour:
- Clock and reset: single clock domain on clk. CLB is asynchronous and active-high.
- Reset values:
  - state = IDLE, INST = NOP_OP, inst_valid = 0, run = 0, halted = 0, load_count = 0, err_overflow = 0.
  - Store contents are not reset.
- States:
  - IDLE (load/wait), RUN (fetching), HALT (stopped).
  - Encoding is free; transitions are fixed as below.
- ld_ready is combinational: (state == IDLE) && (load_count < DEPTH).
- IDLE:
  - On a beat (ld_valid && ld_ready): mem[load_count] <= ld_data; load_count <= load_count + 1.
  - ld_valid while load_count == DEPTH: no write; err_overflow <= 1 (sticky until CLB).
  - start with load_count > 0 → RUN next cycle.
  - start with load_count == 0 and no beat → ignored; stay IDLE.
  - start and a beat in the same cycle: the beat is written, load_count increments, and the block goes to RUN (effective count ≥ 1).
  - In IDLE: inst_valid = 0, run = 0, INST holds its last value.
- RUN:
  - run = 1, asserted combinationally from state.
  - Every cycle: INST <= (PC < load_count) ? mem[PC[AW-1:0]] : NOP_OP; inst_valid <= 1.
  - Latency is exactly one clock from PC to INST.
  - PC ≥ DEPTH is out of range and returns NOP_OP; PC is never wrapped modulo DEPTH.
  - If the word being registered equals HALT_OP, go to HALT in the same edge. INST = HALT_OP is visible with inst_valid = 1 for that one cycle.
  - An out-of-range NOP is never treated as HALT.
  - start and ld_valid are ignored in RUN.
- HALT:
  - run = 0, halted = 1.
  - inst_valid <= 0 on the first HALT cycle; INST holds HALT_OP.
  - start → IDLE, with load_count <= 0, halted <= 0, INST <= NOP_OP.
  - Stale store words are unreachable until reloaded, because load_count is 0.
- Reset mid-operation: CLB in any state forces the reset values immediately; a partially loaded program is discarded (load_count = 0).
- Width rules:
  - load_count is AW+1 bits so it can represent DEPTH.
  - PC is compared as an unsigned 8-bit value against zero-extended load_count.

Test Plan:
1. CLB pulse in mid-RUN → INST = 8'h00, inst_valid = 0, run = 0, load_count = 0 asynchronously, before the next edge.
2. Load 8'h11, 8'h22, 8'h33, 8'hFF, pulse start, drive PC = 0,1,2,3 on successive cycles:
   - INST = 11, 22, 33, FF, each one cycle after its PC, with inst_valid high.
   - halted = 1 and run = 0 after the FF cycle.
3. Load 2 words, run with PC = 5 → INST = 8'h00, no halt. PC = 200 → INST = 8'h00.
4. Hold ld_valid for 33 beats with DEPTH = 32:
   - ld_ready drops after beat 32; load_count = 32.
   - err_overflow = 1; mem[31] holds beat 32's data.
5. start alone in IDLE with load_count = 0 → stays IDLE. start together with a single beat of 8'hFF → RUN; PC = 0 yields FF, then HALT.
6. From HALT pulse start → IDLE, load_count = 0, halted = 0. Reload 8'h44 and run → PC = 0 gives 8'h44; PC = 1 gives 8'h00 (old data not visible).
